// File: rtl/arbitro_alu.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_alu
//  Purpose  : Shares one external combinational ALU between two requesters.
//             Requests are granted round-robin, operands are registered onto
//             the ALU inputs, the ALU result is captured one cycle later and
//             returned, tagged with the requester id, on a valid/ready
//             response channel.
//  Ports    : clk, rst_n (synchronous, active-low)
//             req0_*/req1_* : valido/listo handshake plus op, a, b
//             alu_a, alu_b, alu_sel        : registered ALU inputs
//             alu_resultado, alu_cero      : ALU result and zero flag
//             resp_valido/resp_listo       : response handshake
//             resp_id, resp_resultado, resp_cero : response payload
//  Revision : 1.0  initial release
// ============================================================================
module arbitro_alu #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valido,
    output logic             req0_listo,
    input  logic [2:0]       req0_op,
    input  logic [ANCHO-1:0] req0_a,
    input  logic [ANCHO-1:0] req0_b,
    input  logic             req1_valido,
    output logic             req1_listo,
    input  logic [2:0]       req1_op,
    input  logic [ANCHO-1:0] req1_a,
    input  logic [ANCHO-1:0] req1_b,
    output logic [ANCHO-1:0] alu_a,
    output logic [ANCHO-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [ANCHO-1:0] alu_resultado,
    input  logic             alu_cero,
    output logic             resp_valido,
    input  logic             resp_listo,
    output logic             resp_id,
    output logic [ANCHO-1:0] resp_resultado,
    output logic             resp_cero
);

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        EJECUTA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t r_estado;
    estado_t w_estado_sig;
    logic    r_prioridad;   // requester that wins when both are valid
    logic    r_id;          // requester of the operation in flight
    logic    w_hay;         // at least one requester is valid
    logic    w_id;          // requester chosen by the arbiter
    logic    w_acepta;      // a request transfers at the next edge

    // Round-robin choice: a lone requester always wins, a tie goes to r_prioridad.
    always_comb begin
        w_hay = req0_valido | req1_valido;
        w_id  = 1'b0;
        if (req0_valido && req1_valido) begin
            w_id = r_prioridad;
        end else if (req1_valido) begin
            w_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= LIBRE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Listo is gated by rst_n so no transfer can be signalled while in reset.
    always_comb begin
        w_estado_sig = r_estado;
        req0_listo   = 1'b0;
        req1_listo   = 1'b0;
        case (r_estado)
            LIBRE: begin
                if (w_hay && rst_n) begin
                    req0_listo   = ~w_id;
                    req1_listo   = w_id;
                    w_estado_sig = EJECUTA;
                end
            end
            EJECUTA: begin
                w_estado_sig = ENTREGA;
            end
            ENTREGA: begin
                if (resp_listo) begin
                    w_estado_sig = LIBRE;
                end
            end
            default: begin
                w_estado_sig = LIBRE;
            end
        endcase
    end

    // Grant only ever selects a valid requester, so any listo means transfer.
    assign w_acepta = req0_listo | req1_listo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prioridad    <= 1'b0;
            r_id           <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_sel        <= 3'b000;
            resp_valido    <= 1'b0;
            resp_id        <= 1'b0;
            resp_resultado <= '0;
            resp_cero      <= 1'b0;
        end else begin
            if (w_acepta) begin
                alu_sel <= w_id ? req1_op : req0_op;
                alu_a   <= w_id ? req1_a  : req0_a;
                alu_b   <= w_id ? req1_b  : req0_b;
                r_id    <= w_id;
            end
            // ALU inputs have been stable for a full cycle here.
            if (r_estado == EJECUTA) begin
                resp_resultado <= alu_resultado;
                resp_cero      <= alu_cero;
                resp_id        <= r_id;
                resp_valido    <= 1'b1;
            end
            // Hand priority to the other side once the response is consumed.
            if ((r_estado == ENTREGA) && resp_listo) begin
                resp_valido <= 1'b0;
                r_prioridad <= ~resp_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_alu
//  Purpose  : Self-checking bench for arbitro_alu with a behavioural ALU and
//             a queue-based reference model of the arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arbitro_alu;

    localparam int ANCHO = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valido, req0_listo;
    logic [2:0]       req0_op;
    logic [ANCHO-1:0] req0_a, req0_b;
    logic             req1_valido, req1_listo;
    logic [2:0]       req1_op;
    logic [ANCHO-1:0] req1_a, req1_b;
    logic [ANCHO-1:0] alu_a, alu_b;
    logic [2:0]       alu_sel;
    logic [ANCHO-1:0] alu_resultado;
    logic             alu_cero;
    logic             resp_valido, resp_listo, resp_id, resp_cero;
    logic [ANCHO-1:0] resp_resultado;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic             id;
        logic [ANCHO-1:0] res;
    } exp_t;

    always #5 clk = ~clk;

    arbitro_alu #(.ANCHO(ANCHO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valido(req0_valido), .req0_listo(req0_listo), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valido(req1_valido), .req1_listo(req1_listo), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_resultado(alu_resultado), .alu_cero(alu_cero),
        .resp_valido(resp_valido), .resp_listo(resp_listo), .resp_id(resp_id),
        .resp_resultado(resp_resultado), .resp_cero(resp_cero)
    );

    // Behavioural ALU: add, sub, and, or, signed set-less-than; others give 0.
    function automatic logic [ANCHO-1:0] alu_ref(input logic [2:0] op,
                                                 input logic [ANCHO-1:0] a,
                                                 input logic [ANCHO-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_resultado = alu_ref(alu_sel, alu_a, alu_b);
        alu_cero      = (alu_resultado == '0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0_valido = 1'b0; req1_valido = 1'b0; resp_listo = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Issues one operation and returns what came back (no checking here).
    task automatic run_one(input logic id, input logic [2:0] op,
                           input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                           output logic got_id, output logic [ANCHO-1:0] res,
                           output logic cero, output logic timeout);
        bit acc = 0;
        bit got = 0;
        timeout = 1'b0; got_id = 1'b0; res = '0; cero = 1'b0;
        resp_listo = 1'b1;
        if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valido = 1'b1; end
        else    begin req0_op = op; req0_a = a; req0_b = b; req0_valido = 1'b1; end
        for (int i = 0; i < 10; i++) begin
            #1;
            if (id ? req1_listo : req0_listo) begin acc = 1; step(); break; end
            step();
        end
        if (id) req1_valido = 1'b0; else req0_valido = 1'b0;
        if (!acc) begin timeout = 1'b1; return; end
        for (int i = 0; i < 10; i++) begin
            if (resp_valido) begin
                got_id = resp_id; res = resp_resultado; cero = resp_cero;
                got = 1; step(); break;
            end
            step();
        end
        if (!got) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valido = 1'b0; req1_valido = 1'b0; resp_listo = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
        step();
        step();
        req0_valido = 1'b1; req1_valido = 1'b1;
        #1;
        total++; if (req0_listo !== 1'b0) $display("FAIL reset_listo0: got %b exp 0", req0_listo); else passed++;
        total++; if (req1_listo !== 1'b0) $display("FAIL reset_listo1: got %b exp 0", req1_listo); else passed++;
        total++; if (resp_valido !== 1'b0) $display("FAIL reset_resp_valido: got %b exp 0", resp_valido); else passed++;
        total++; if (resp_id !== 1'b0) $display("FAIL reset_resp_id: got %b exp 0", resp_id); else passed++;
        total++; if (resp_resultado !== '0) $display("FAIL reset_resultado: got %h exp 0", resp_resultado); else passed++;
        total++; if (resp_cero !== 1'b0) $display("FAIL reset_cero: got %b exp 0", resp_cero); else passed++;
        total++; if ({alu_a, alu_b, alu_sel} !== '0) $display("FAIL reset_alu_in: got %h/%h/%b exp 0", alu_a, alu_b, alu_sel); else passed++;
        req0_valido = 1'b0; req1_valido = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req0_op = 3'b000; req0_a = 5; req0_b = 7; req0_valido = 1'b1; resp_listo = 1'b1;
        #1;
        total++; if (req0_listo !== 1'b1) $display("FAIL single_listo0: got %b exp 1", req0_listo); else passed++;
        total++; if (req1_listo !== 1'b0) $display("FAIL single_listo1: got %b exp 0", req1_listo); else passed++;
        step();
        req0_valido = 1'b0;
        total++; if (resp_valido !== 1'b0) $display("FAIL single_early_valido: got %b exp 0", resp_valido); else passed++;
        total++; if (alu_a !== 5 || alu_b !== 7) $display("FAIL single_alu_in: got %0d/%0d exp 5/7", alu_a, alu_b); else passed++;
        step();
        total++; if (resp_valido !== 1'b1) $display("FAIL single_valido: got %b exp 1", resp_valido); else passed++;
        total++; if (resp_resultado !== 12) $display("FAIL single_resultado: got %0d exp 12", resp_resultado); else passed++;
        total++; if (resp_cero !== 1'b0 || resp_id !== 1'b0) $display("FAIL single_cero_id: got %b/%b exp 0/0", resp_cero, resp_id); else passed++;
        step();
        total++; if (resp_valido !== 1'b0) $display("FAIL single_drop: got %b exp 0", resp_valido); else passed++;
    endtask

    task automatic test_both();
        do_reset();
        req0_op = 3'b001; req0_a = 9;     req0_b = 9;
        req1_op = 3'b011; req1_a = 'hF0;  req1_b = 'h0F;
        req0_valido = 1'b1; req1_valido = 1'b1; resp_listo = 1'b1;
        #1;
        total++; if ({req0_listo, req1_listo} !== 2'b10) $display("FAIL both_first_grant: got %b%b exp 10", req0_listo, req1_listo); else passed++;
        step();
        req0_valido = 1'b0;
        step();
        total++; if (resp_valido !== 1'b1 || resp_id !== 1'b0) $display("FAIL both_resp0: got v=%b id=%b exp v=1 id=0", resp_valido, resp_id); else passed++;
        total++; if (resp_resultado !== 0 || resp_cero !== 1'b1) $display("FAIL both_res0: got %h cero=%b exp 0 cero=1", resp_resultado, resp_cero); else passed++;
        total++; if (req1_listo !== 1'b0) $display("FAIL both_listo_entrega: got %b exp 0", req1_listo); else passed++;
        step();
        total++; if (req1_listo !== 1'b1) $display("FAIL both_second_grant: got %b exp 1", req1_listo); else passed++;
        step();
        req1_valido = 1'b0;
        step();
        total++; if (resp_resultado !== 'hFF || resp_id !== 1'b1 || resp_cero !== 1'b0) $display("FAIL both_res1: got %h id=%b cero=%b exp ff id=1 cero=0", resp_resultado, resp_id, resp_cero); else passed++;
        step();
    endtask

    task automatic test_alternate();
        int n = 0;
        int last = -1;
        do_reset();
        req0_op = 3'b000; req0_a = $urandom; req0_b = $urandom;
        req1_op = 3'b010; req1_a = $urandom; req1_b = $urandom;
        req0_valido = 1'b1; req1_valido = 1'b1; resp_listo = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            if (req0_listo || req1_listo) begin
                total++; if (int'(req1_listo) == last) $display("FAIL alt_double_grant: got side %0d twice", last); else passed++;
                last = int'(req1_listo);
            end
            if (resp_valido) begin
                total++; if (resp_id !== n[0]) $display("FAIL alt_id: op %0d got %b exp %b", n, resp_id, n[0]); else passed++;
                total++;
                if (resp_resultado !== (n[0] ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b)))
                    $display("FAIL alt_resultado: op %0d got %h", n, resp_resultado);
                else passed++;
                n++;
            end
            step();
        end
        req0_valido = 1'b0; req1_valido = 1'b0;
        total++; if (n != 6) $display("FAIL alt_count: got %0d exp 6", n); else passed++;
        step();
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_op = 3'b000; req0_a = 1; req0_b = 2; req0_valido = 1'b1; resp_listo = 1'b0;
        step();
        req0_valido = 1'b0;
        req1_op = 3'b011; req1_a = 'h30; req1_b = 'h03; req1_valido = 1'b1;
        step();
        total++; if (resp_valido !== 1'b1 || resp_resultado !== 3) $display("FAIL bp_first: got v=%b %h exp v=1 3", resp_valido, resp_resultado); else passed++;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (resp_valido !== 1'b1 || resp_resultado !== 3 || resp_id !== 1'b0 || req0_listo !== 1'b0 || req1_listo !== 1'b0)
                $display("FAIL bp_hold: cycle %0d got v=%b res=%h id=%b listo=%b%b exp v=1 res=3 id=0 listo=00",
                         i, resp_valido, resp_resultado, resp_id, req0_listo, req1_listo);
            else passed++;
        end
        resp_listo = 1'b1;
        #1;
        total++; if (req1_listo !== 1'b0) $display("FAIL bp_listo_same_cycle: got %b exp 0", req1_listo); else passed++;
        step();
        total++; if (resp_valido !== 1'b0 || req1_listo !== 1'b1) $display("FAIL bp_release: got v=%b listo1=%b exp v=0 listo1=1", resp_valido, req1_listo); else passed++;
        step();
        req1_valido = 1'b0;
        step();
        total++; if (resp_resultado !== 'h33 || resp_id !== 1'b1) $display("FAIL bp_next: got %h id=%b exp 33 id=1", resp_resultado, resp_id); else passed++;
        step();
    endtask

    task automatic test_slt();
        logic gid, gc, to;
        logic [ANCHO-1:0] gr;
        run_one(1'b1, 3'b100, 3, 4, gid, gr, gc, to);
        total++; if (to || gid !== 1'b1 || gr !== 1 || gc !== 1'b0) $display("FAIL slt_3_4: got to=%b id=%b res=%h cero=%b exp 0/1/1/0", to, gid, gr, gc); else passed++;
        run_one(1'b1, 3'b100, 4, 3, gid, gr, gc, to);
        total++; if (to || gid !== 1'b1 || gr !== 0 || gc !== 1'b1) $display("FAIL slt_4_3: got to=%b id=%b res=%h cero=%b exp 0/1/0/1", to, gid, gr, gc); else passed++;
        run_one(1'b1, 3'b111, 'h1234, 'h5678, gid, gr, gc, to);
        total++; if (to || gr !== 0 || gc !== 1'b1) $display("FAIL op_111: got to=%b res=%h cero=%b exp 0/0/1", to, gr, gc); else passed++;
    endtask

    task automatic test_reset_mid();
        logic gid, gc, to;
        logic [ANCHO-1:0] gr;
        do_reset();
        run_one(1'b0, 3'b000, 10, 20, gid, gr, gc, to);
        total++; if (to || gr !== 30 || gid !== 1'b0) $display("FAIL mid_pre: got to=%b res=%0d id=%b exp 0/30/0", to, gr, gid); else passed++;
        req1_op = 3'b000; req1_a = 1; req1_b = 1; req1_valido = 1'b1;
        #1;
        total++; if (req1_listo !== 1'b1) $display("FAIL mid_grant: got %b exp 1", req1_listo); else passed++;
        step();
        req1_valido = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (resp_valido !== 1'b0 || {alu_a, alu_b, alu_sel} !== '0 || resp_resultado !== '0 || resp_id !== 1'b0 || resp_cero !== 1'b0)
            $display("FAIL mid_reset_vals: got v=%b alu=%h/%h/%b res=%h id=%b cero=%b exp all 0",
                     resp_valido, alu_a, alu_b, alu_sel, resp_resultado, resp_id, resp_cero);
        else passed++;
        req0_op = 3'b001; req0_a = 50; req0_b = 8; req0_valido = 1'b1;
        req1_op = 3'b000; req1_a = 2;  req1_b = 2; req1_valido = 1'b1;
        resp_listo = 1'b1;
        #1;
        total++; if ({req0_listo, req1_listo} !== 2'b10) $display("FAIL mid_prio_reset: got %b%b exp 10", req0_listo, req1_listo); else passed++;
        step();
        req0_valido = 1'b0; req1_valido = 1'b0;
        total++; if (resp_valido !== 1'b0) $display("FAIL mid_no_resp: got %b exp 0", resp_valido); else passed++;
        step();
        total++; if (resp_valido !== 1'b1 || resp_resultado !== 42 || resp_id !== 1'b0) $display("FAIL mid_after: got v=%b res=%0d id=%b exp 1/42/0", resp_valido, resp_resultado, resp_id); else passed++;
        step();
    endtask

    // Random traffic: requesters hold an operation until accepted; the model
    // predicts grants from pending requests, outstanding count and priority.
    task automatic test_random();
        exp_t             q[$];
        exp_t             e;
        logic             pend[2];
        logic [2:0]       pop[2];
        logic [ANCHO-1:0] pa[2], pb[2];
        logic             prio = 1'b0;
        int               outstanding = 0;
        logic             exp0, exp1;
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    pop[k]  = 3'($urandom_range(0, 7));
                    pa[k]   = $urandom;
                    pb[k]   = ($urandom_range(0, 3) == 0) ? pa[k] : $urandom;
                end
            end
            req0_valido = pend[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
            req1_valido = pend[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
            resp_listo  = ($urandom_range(0, 3) != 0);
            #1;
            exp0 = 1'b0; exp1 = 1'b0;
            if (outstanding == 0) begin
                if (pend[0] && pend[1]) begin
                    if (prio) exp1 = 1'b1; else exp0 = 1'b1;
                end else if (pend[0]) exp0 = 1'b1;
                else if (pend[1]) exp1 = 1'b1;
            end
            total++; if ({req0_listo, req1_listo} !== {exp0, exp1}) $display("FAIL rnd_grant: cycle %0d got %b%b exp %b%b", cyc, req0_listo, req1_listo, exp0, exp1); else passed++;
            if (resp_valido && resp_listo) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_unexpected_resp: cycle %0d got id=%b res=%h exp none", cyc, resp_id, resp_resultado);
                end else begin
                    passed++;
                    e = q.pop_front();
                    total++; if (resp_id !== e.id) $display("FAIL rnd_id: cycle %0d got %b exp %b", cyc, resp_id, e.id); else passed++;
                    total++; if (resp_resultado !== e.res) $display("FAIL rnd_resultado: cycle %0d got %h exp %h", cyc, resp_resultado, e.res); else passed++;
                    total++; if (resp_cero !== (e.res == '0)) $display("FAIL rnd_cero: cycle %0d got %b exp %b", cyc, resp_cero, (e.res == '0)); else passed++;
                    prio = ~e.id;
                    outstanding--;
                end
            end
            if (req0_listo && pend[0]) begin
                q.push_back('{id: 1'b0, res: alu_ref(pop[0], pa[0], pb[0])});
                pend[0] = 1'b0; outstanding++;
            end else if (req1_listo && pend[1]) begin
                q.push_back('{id: 1'b1, res: alu_ref(pop[1], pa[1], pb[1])});
                pend[1] = 1'b0; outstanding++;
            end
            step();
        end
        req0_valido = 1'b0; req1_valido = 1'b0; resp_listo = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            if (resp_valido) begin
                e = q.pop_front();
                total++; if (resp_id !== e.id || resp_resultado !== e.res) $display("FAIL rnd_drain: got id=%b res=%h exp id=%b res=%h", resp_id, resp_resultado, e.id, e.res); else passed++;
            end
            step();
        end
        total++; if (q.size() != 0) $display("FAIL rnd_leftover: got %0d pending exp 0", q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_backpressure();
        test_slt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
